// File: rtl/ama_riscv_bp_pht_seq_pkg.sv
// Shared types and default widths for the PHT write-port sequencer.
package ama_riscv_bp_pht_seq_pkg;

  localparam int unsigned BP_IDX_BITS   = 5;
  localparam int unsigned BP_CNT_BITS   = 3;
  localparam int unsigned BP_FIFO_DEPTH = 4;

  typedef enum logic {
    SEQ_SWEEP,
    SEQ_IDLE
  } bp_seq_state_t;

  typedef struct packed {
    logic [BP_IDX_BITS-1:0] idx;
    logic [BP_CNT_BITS-1:0] val;
  } bp_pht_wr_t;

endpackage

// File: rtl/ama_riscv_bp_pht_seq_if.sv
// Update/clear inputs and PHT write-port outputs of the PHT sequencer.
interface ama_riscv_bp_pht_seq_if
  import ama_riscv_bp_pht_seq_pkg::*;
#(
  parameter int unsigned IDX_BITS = BP_IDX_BITS,
  parameter int unsigned CNT_BITS = BP_CNT_BITS
);
  logic                clr_req;
  logic                up_valid;
  logic [IDX_BITS-1:0] up_idx;
  logic [CNT_BITS-1:0] up_val;
  logic                pht_we;
  logic [IDX_BITS-1:0] pht_widx;
  logic [CNT_BITS-1:0] pht_wval;
  logic                pred_block;
  logic                clr_busy;
  logic                up_drop;

  modport master (
    output clr_req, up_valid, up_idx, up_val,
    input  pht_we, pht_widx, pht_wval, pred_block, clr_busy, up_drop
  );

  modport slave (
    input  clr_req, up_valid, up_idx, up_val,
    output pht_we, pht_widx, pht_wval, pred_block, clr_busy, up_drop
  );
endinterface

// File: rtl/ama_riscv_bp_up_fifo.sv
// Small synchronous FIFO buffering PHT updates while a clear sweep owns the port.
module ama_riscv_bp_up_fifo
  import ama_riscv_bp_pht_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = BP_FIFO_DEPTH,
  parameter type         entry_t = bp_pht_wr_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t din,
  output entry_t dout,
  output logic   full,
  output logic   empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wp, rp;
  entry_t        mem [DEPTH];
  logic          do_push, do_pop;

  // Wrap bit separates full from empty when the address bits match.
  assign empty   = (wp == rp);
  assign full    = (wp[AW-1:0] == rp[AW-1:0]) && (wp[PW-1] != rp[PW-1]);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + PW'(do_push);
      rp <= rp + PW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ama_riscv_bp_pht_seq.sv
// PHT write-port sequencer: clear sweep vs. resolve-time updates, FIFO-buffered.
// Optional statistics outputs enabled by AMA_RISCV_BP_PHT_SEQ_STATS_EN.
module ama_riscv_bp_pht_seq
  import ama_riscv_bp_pht_seq_pkg::*;
#(
  parameter int unsigned IDX_BITS   = BP_IDX_BITS,
  parameter int unsigned CNT_BITS   = BP_CNT_BITS,
  parameter int unsigned INIT_VAL   = 0,
  parameter int unsigned FIFO_DEPTH = BP_FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  ama_riscv_bp_pht_seq_if.slave bus
`ifdef AMA_RISCV_BP_PHT_SEQ_STATS_EN
  ,
  output logic [15:0]                   stat_drops,
  output logic [15:0]                   stat_sweeps,
  output logic [$clog2(FIFO_DEPTH):0]   stat_fifo_max
`endif
);
  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic [CNT_BITS-1:0] val;
  } wr_t;

  bp_seq_state_t       state;
  logic [IDX_BITS-1:0] sweep_idx;
  logic                we_q, drop_q, block_q;
  logic [IDX_BITS-1:0] widx_q;
  logic [CNT_BITS-1:0] wval_q;

  wr_t  fifo_din, fifo_head;
  logic fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic drop, sweep_done;

  ama_riscv_bp_up_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (wr_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A clear supersedes every same-cycle update, so nothing is pushed or dropped.
  always_comb begin
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    fifo_flush   = bus.clr_req;
    fifo_din.idx = bus.up_idx;
    fifo_din.val = bus.up_val;
    drop         = 1'b0;
    sweep_done   = 1'b0;
    if (!bus.clr_req) begin
      if (state == SEQ_SWEEP) begin
        fifo_push  = bus.up_valid;
        drop       = bus.up_valid && fifo_full;
        sweep_done = (sweep_idx == '1);
      end else begin
        fifo_pop  = !fifo_empty;
        fifo_push = bus.up_valid && !fifo_empty;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEQ_SWEEP;
      sweep_idx <= '0;
      we_q      <= 1'b0;
      widx_q    <= '0;
      wval_q    <= '0;
      drop_q    <= 1'b0;
      block_q   <= 1'b1;
    end else begin
      we_q    <= 1'b0;
      drop_q  <= drop;
      block_q <= (state == SEQ_SWEEP) || bus.clr_req;
      if (bus.clr_req) begin
        state     <= SEQ_SWEEP;
        sweep_idx <= '0;
      end else if (state == SEQ_SWEEP) begin
        we_q      <= 1'b1;
        widx_q    <= sweep_idx;
        wval_q    <= CNT_BITS'(INIT_VAL);
        sweep_idx <= sweep_done ? '0 : sweep_idx + IDX_BITS'(1);
        if (sweep_done) state <= SEQ_IDLE;
      end else if (!fifo_empty) begin
        we_q   <= 1'b1;
        widx_q <= fifo_head.idx;
        wval_q <= fifo_head.val;
      end else if (bus.up_valid) begin
        we_q   <= 1'b1;
        widx_q <= bus.up_idx;
        wval_q <= bus.up_val;
      end
    end
  end

  assign bus.pht_we     = we_q;
  assign bus.pht_widx   = widx_q;
  assign bus.pht_wval   = wval_q;
  assign bus.pred_block = block_q;
  assign bus.clr_busy   = block_q;
  assign bus.up_drop    = drop_q;

`ifdef AMA_RISCV_BP_PHT_SEQ_STATS_EN
  localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;
  logic [PW-1:0] occ;
  logic          push_acc, pop_acc;

  // Occupancy is tracked here with the same acceptance rules the FIFO applies.
  assign push_acc = fifo_push && (!fifo_full || fifo_pop);
  assign pop_acc  = fifo_pop && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_drops    <= '0;
      stat_sweeps   <= '0;
      stat_fifo_max <= '0;
      occ           <= '0;
    end else begin
      if (drop && (stat_drops != '1)) stat_drops <= stat_drops + 16'd1;
      if (sweep_done && (stat_sweeps != '1)) stat_sweeps <= stat_sweeps + 16'd1;
      occ <= fifo_flush ? '0 : occ + PW'(push_acc) - PW'(pop_acc);
      if (occ > stat_fifo_max) stat_fifo_max <= occ;
    end
  end
`endif

endmodule

// File: tb/tb_ama_riscv_bp_pht_seq.sv
// Self-checking bench for the PHT sequencer against a queue-based reference model.
module tb_ama_riscv_bp_pht_seq;
  localparam int unsigned IDX_BITS   = 5;
  localparam int unsigned CNT_BITS   = 3;
  localparam int unsigned INIT_VAL   = 1;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned NENT       = 1 << IDX_BITS;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  ama_riscv_bp_pht_seq_if #(.IDX_BITS(IDX_BITS), .CNT_BITS(CNT_BITS)) bus ();

  ama_riscv_bp_pht_seq #(
    .IDX_BITS   (IDX_BITS),
    .CNT_BITS   (CNT_BITS),
    .INIT_VAL   (INIT_VAL),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: sweep position, pending-update queue, expected outputs.
  typedef struct { int idx; int val; } upd_t;
  upd_t q[$];
  bit   m_sweep;
  int   m_pos;
  int   e_we, e_idx, e_val, e_drop, e_block;

  task automatic model_reset();
    q.delete();
    m_sweep = 1'b1;
    m_pos   = 0;
  endtask

  task automatic model_step(input int clr, input int uv, input int ui, input int uval);
    upd_t u;
    e_we    = 0;
    e_drop  = 0;
    e_block = (m_sweep || clr != 0) ? 1 : 0;
    u.idx   = ui;
    u.val   = uval;
    if (clr != 0) begin
      q.delete();
      m_sweep = 1'b1;
      m_pos   = 0;
    end else if (m_sweep) begin
      e_we  = 1;
      e_idx = m_pos;
      e_val = INIT_VAL;
      if (uv != 0) begin
        if (q.size() < FIFO_DEPTH) q.push_back(u);
        else e_drop = 1;
      end
      m_pos++;
      if (m_pos == NENT) begin
        m_sweep = 1'b0;
        m_pos   = 0;
      end
    end else if (q.size() > 0) begin
      upd_t h;
      h     = q.pop_front();
      e_we  = 1;
      e_idx = h.idx;
      e_val = h.val;
      if (uv != 0) q.push_back(u);
    end else if (uv != 0) begin
      e_we  = 1;
      e_idx = ui;
      e_val = uval;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_we"},    32'(bus.pht_we),     0);
    chk({tag, "_widx"},  32'(bus.pht_widx),   0);
    chk({tag, "_wval"},  32'(bus.pht_wval),   0);
    chk({tag, "_drop"},  32'(bus.up_drop),    0);
    chk({tag, "_block"}, 32'(bus.pred_block), 1);
    chk({tag, "_busy"},  32'(bus.clr_busy),   1);
  endtask

  task automatic cycle();
    model_step(int'(bus.clr_req), int'(bus.up_valid), int'(bus.up_idx), int'(bus.up_val));
    @(posedge clk);
    #1;
    chk("we",    32'(bus.pht_we),     32'(e_we));
    chk("block", 32'(bus.pred_block), 32'(e_block));
    chk("busy",  32'(bus.clr_busy),   32'(e_block));
    chk("drop",  32'(bus.up_drop),    32'(e_drop));
    if (e_we != 0) begin
      chk("widx", 32'(bus.pht_widx), 32'(e_idx));
      chk("wval", 32'(bus.pht_wval), 32'(e_val));
    end
  endtask

  task automatic drive(input logic clr, input logic uv, input int ui, input int uval);
    bus.clr_req  = clr;
    bus.up_valid = uv;
    bus.up_idx   = IDX_BITS'(ui);
    bus.up_val   = CNT_BITS'(uval);
  endtask

  task automatic push_rand();
    drive(1'b0, 1'b1, int'($urandom_range(NENT - 1)), int'($urandom_range((1 << CNT_BITS) - 1)));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Power-up sweep with no traffic, then idle.
    repeat (NENT + 3) cycle();

    // Direct bypass writes, back to back.
    drive(1'b0, 1'b1, 5, 3); cycle();
    drive(1'b0, 1'b1, 6, 1); cycle();
    drive(1'b0, 1'b1, 7, 6); cycle();
    drive(1'b0, 1'b0, 0, 0); cycle();

    // Clear from idle, six updates during the sweep overflow a 4-deep FIFO.
    drive(1'b1, 1'b0, 0, 0); cycle();
    for (int i = 0; i < 6; i++) begin
      push_rand();
      cycle();
    end
    drive(1'b0, 1'b0, 0, 0);
    repeat (NENT) cycle();

    // Leave 2 entries pending in idle, then clear together with an update.
    drive(1'b1, 1'b0, 0, 0); cycle();
    drive(1'b0, 1'b0, 0, 0);
    repeat (NENT - 3) cycle();
    for (int i = 0; i < 3; i++) begin
      push_rand();
      cycle();
    end
    drive(1'b0, 1'b0, 0, 0); cycle();
    drive(1'b1, 1'b1, 9, 2); cycle();

    // Clear again while the sweep index is 20.
    drive(1'b0, 1'b0, 0, 0);
    repeat (20) cycle();
    drive(1'b1, 1'b0, 0, 0); cycle();
    drive(1'b0, 1'b0, 0, 0);
    repeat (NENT + 2) cycle();

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(39) == 0), ($urandom_range(1) == 1),
            int'($urandom_range(NENT - 1)), int'($urandom_range((1 << CNT_BITS) - 1)));
      cycle();
    end

    // Asynchronous reset in the middle of draining the FIFO.
    drive(1'b1, 1'b0, 0, 0); cycle();
    for (int i = 0; i < 4; i++) begin
      push_rand();
      cycle();
    end
    drive(1'b0, 1'b0, 0, 0);
    repeat (NENT - 4) cycle();
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("arst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NENT + 4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
